// File: rtl/phase_error_quantizer_if.sv
// ============================================================================
//  Module      : phase_error_quantizer_if
//  Description : Bundle of the phase-error quantizer signals. The two sampled
//                clocks (ref_in, fb_in) travel toward the quantizer. The
//                measurement result (master_out, lead, valid) travels back
//                toward the loop filter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface phase_error_quantizer_if #(
    parameter int inout_width = 8
);

    // Reference clock and divided DCO feedback, asynchronous to the quantizer clock
    logic                   ref_in;
    logic                   fb_in;

    // Measurement result
    logic [inout_width-1:0] master_out;
    logic                   lead;
    logic                   valid;

    // Stimulus / loop-filter side
    modport master (
        output ref_in,
        output fb_in,
        input  master_out,
        input  lead,
        input  valid
    );

    // Quantizer side
    modport slave (
        input  ref_in,
        input  fb_in,
        output master_out,
        output lead,
        output valid
    );

endinterface : phase_error_quantizer_if

`default_nettype wire

// File: rtl/phase_error_quantizer.sv
// ============================================================================
//  Module      : phase_error_quantizer
//  Description : Bang-bang / time-to-digital phase detector for a digital PLL.
//                It measures how many clk cycles separate a rising edge of the
//                reference clock from a rising edge of the divided DCO
//                feedback. The result is a saturating unsigned magnitude plus
//                a sign (lead = 1 when feedback came first).
//                Optional macro PEQ_INPUT_SYNC_EN inserts a two-flop
//                synchronizer in front of each edge detector. This adds two
//                cycles of latency equally to both paths, so the measured
//                magnitudes are unchanged.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_error_quantizer #(
    parameter int inout_width = 8,
    parameter int max_count   = 2**inout_width - 1
) (
    input  logic                   clk,
    input  logic                   rst,
    phase_error_quantizer_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic [inout_width-1:0] c_max_count = inout_width'(max_count);
    localparam logic [inout_width-1:0] c_cnt_one   = inout_width'(1);
    localparam logic [inout_width-1:0] c_cnt_zero  = '0;

    localparam logic [1:0] c_st_idle      = 2'd0;
    localparam logic [1:0] c_st_ref_first = 2'd1;
    localparam logic [1:0] c_st_fb_first  = 2'd2;

    // ------------------------------------------------------------------------
    // Optional input synchronizer
    // ------------------------------------------------------------------------
    // c_prime_cycles covers the flop depth from the pin to the edge-detect
    // register. For that many cycles after reset, the "previous" flop copies
    // whatever value enters the edge register. An input already high at
    // reset release is therefore taken as a level, not as a rising edge.
    logic w_ref_stage;
    logic w_fb_stage;

`ifdef PEQ_INPUT_SYNC_EN
    localparam logic [1:0] c_prime_cycles = 2'd3;

    logic [1:0] r_ref_sync;
    logic [1:0] r_fb_sync;

    // Two-flop synchronizers on both clock inputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_sync <= 2'b00;
            r_fb_sync  <= 2'b00;
        end else begin
            r_ref_sync <= {r_ref_sync[0], bus.ref_in};
            r_fb_sync  <= {r_fb_sync[0],  bus.fb_in};
        end
    end

    assign w_ref_stage = r_ref_sync[1];
    assign w_fb_stage  = r_fb_sync[1];
`else
    localparam logic [1:0] c_prime_cycles = 2'd1;

    assign w_ref_stage = bus.ref_in;
    assign w_fb_stage  = bus.fb_in;
`endif

    // ------------------------------------------------------------------------
    // Post-reset priming counter
    // ------------------------------------------------------------------------
    logic [1:0] r_prime_cnt;
    logic       w_primed;

    assign w_primed = (r_prime_cnt == c_prime_cycles);

    // Count the first few cycles after reset until the input pipeline is full
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prime_cnt <= 2'd0;
        end else if (!w_primed) begin
            r_prime_cnt <= r_prime_cnt + 2'd1;
        end
    end

    // ------------------------------------------------------------------------
    // Edge detection
    // ------------------------------------------------------------------------
    logic r_ref_cur;
    logic r_ref_prev;
    logic r_fb_cur;
    logic r_fb_prev;
    logic w_ref_edge;
    logic w_fb_edge;
    logic w_both_edge;

    // Register the conditioned inputs and keep the previous sample for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ref_cur  <= 1'b0;
            r_ref_prev <= 1'b0;
            r_fb_cur   <= 1'b0;
            r_fb_prev  <= 1'b0;
        end else begin
            r_ref_cur  <= w_ref_stage;
            r_fb_cur   <= w_fb_stage;
            r_ref_prev <= w_primed ? r_ref_cur : w_ref_stage;
            r_fb_prev  <= w_primed ? r_fb_cur  : w_fb_stage;
        end
    end

    assign w_ref_edge  = r_ref_cur & ~r_ref_prev;
    assign w_fb_edge   = r_fb_cur  & ~r_fb_prev;
    assign w_both_edge = w_ref_edge & w_fb_edge;

    // ------------------------------------------------------------------------
    // Measurement FSM
    // ------------------------------------------------------------------------
    logic [1:0]             r_state;
    logic [inout_width-1:0] r_cnt;
    logic [inout_width-1:0] w_cnt_inc;
    logic [inout_width-1:0] r_master_out;
    logic                   r_lead;
    logic                   r_valid;

    // Saturating increment: the counter never wraps past max_count
    assign w_cnt_inc = (r_cnt >= c_max_count) ? c_max_count : (r_cnt + c_cnt_one);

    // Track which edge came first, count the gap and publish the result on the closing edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_st_idle;
            r_cnt        <= c_cnt_zero;
            r_master_out <= c_cnt_zero;
            r_lead       <= 1'b0;
            r_valid      <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (w_both_edge) begin
                        // Perfectly aligned edges: zero error, sign left as it was
                        r_master_out <= c_cnt_zero;
                        r_valid      <= 1'b1;
                    end else if (w_ref_edge) begin
                        r_state <= c_st_ref_first;
                        r_cnt   <= c_cnt_one;
                    end else if (w_fb_edge) begin
                        r_state <= c_st_fb_first;
                        r_cnt   <= c_cnt_one;
                    end
                end

                c_st_ref_first: begin
                    if (w_both_edge) begin
                        // Close this measurement; the new ref edge opens the next one
                        r_master_out <= r_cnt;
                        r_lead       <= 1'b0;
                        r_valid      <= 1'b1;
                        r_cnt        <= c_cnt_one;
                    end else if (w_fb_edge) begin
                        r_master_out <= r_cnt;
                        r_lead       <= 1'b0;
                        r_valid      <= 1'b1;
                        r_cnt        <= c_cnt_zero;
                        r_state      <= c_st_idle;
                    end else if (w_ref_edge) begin
                        // Second ref edge before any fb edge: cycle slip
                        r_master_out <= c_max_count;
                        r_lead       <= 1'b0;
                        r_valid      <= 1'b1;
                        r_cnt        <= c_cnt_one;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                c_st_fb_first: begin
                    if (w_both_edge) begin
                        r_master_out <= r_cnt;
                        r_lead       <= 1'b1;
                        r_valid      <= 1'b1;
                        r_cnt        <= c_cnt_one;
                    end else if (w_ref_edge) begin
                        r_master_out <= r_cnt;
                        r_lead       <= 1'b1;
                        r_valid      <= 1'b1;
                        r_cnt        <= c_cnt_zero;
                        r_state      <= c_st_idle;
                    end else if (w_fb_edge) begin
                        // Second fb edge before any ref edge: cycle slip
                        r_master_out <= c_max_count;
                        r_lead       <= 1'b1;
                        r_valid      <= 1'b1;
                        r_cnt        <= c_cnt_one;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_cnt   <= c_cnt_zero;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.master_out = r_master_out;
    assign bus.lead       = r_lead;
    assign bus.valid      = r_valid;

endmodule : phase_error_quantizer

`default_nettype wire
